// File: rtl/fetch_queue.sv
// Fetch-to-decode instruction queue: circular buffer of {Instr, PC4, PC} entries between fetch and decode.
// Latency: push to D_valid is 1 cycle; with FETCH_QUEUE_BYPASS_EN an empty queue forwards the fetch word combinationally.
// Backpressure: IF_en = !full from registered occupancy only, so a pop while full never admits a same-cycle push.
// Optional feature macro: FETCH_QUEUE_BYPASS_EN (empty-queue bypass path).
module fetch_queue #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic [31:0]              Instr,
    input  logic [31:0]              PC4,
    input  logic [31:0]              PC_in,
    input  logic                     flush,
    input  logic                     D_ready,
    output logic                     IF_en,
    output logic                     D_valid,
    output logic [31:0]              D_Instr,
    output logic [31:0]              D_PC4,
    output logic [31:0]              D_PC,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    // Entry storage; contents are only ever observed through a valid head.
    logic [31:0] instr_mem [DEPTH];
    logic [31:0] pc4_mem   [DEPTH];
    logic [31:0] pc_mem    [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;

    logic full;
    logic head_vld;
    logic byp_vld;
    logic push;
    logic pop;

    assign full     = (count_q == CW'(DEPTH));
    assign head_vld = (count_q != '0);
    assign IF_en    = !full;
    assign count    = count_q;

`ifdef FETCH_QUEUE_BYPASS_EN
    // Empty queue: present the fetch word directly; reset masks it so outputs stay nop.
    assign byp_vld = !reset && !head_vld && in_valid && !flush;
    // A bypassed word that decode accepts now is never stored.
    assign push    = in_valid && !full && !flush && !(byp_vld && D_ready);
`else
    assign byp_vld = 1'b0;
    assign push    = in_valid && !full && !flush;
`endif

    // Only stored entries are popped; a bypassed word is consumed without touching pointers.
    assign pop = head_vld && D_ready && !flush;

    // Head selection: stored entry, else bypass word, else nop (all zero).
    always_comb begin
        D_valid = 1'b0;
        D_Instr = '0;
        D_PC4   = '0;
        D_PC    = '0;
        if (head_vld) begin
            D_valid = 1'b1;
            D_Instr = instr_mem[rd_ptr_q];
            D_PC4   = pc4_mem[rd_ptr_q];
            D_PC    = pc_mem[rd_ptr_q];
        end else if (byp_vld) begin
            D_valid = 1'b1;
            D_Instr = Instr;
            D_PC4   = PC4;
            D_PC    = PC_in;
        end
    end

    // Next pointer/occupancy: flush wins over any push or pop in the same cycle.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control state register with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry write at the write pointer; no reset needed since unread slots are never exposed.
    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem[wr_ptr_q] <= Instr;
            pc4_mem[wr_ptr_q]   <= PC4;
            pc_mem[wr_ptr_q]    <= PC_in;
        end
    end

endmodule
